// File: rtl/sprite_fetch_ctrl_if.sv
// Pixel-stream, sprite-ROM and VGA-output signals of the sprite fetch controller.
// master drives timing and ROM data, slave is the controller.
interface sprite_fetch_ctrl_if;
  logic        px_en;
  logic        frame_start;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        active;
  logic [1:0]  sync_in;
  logic [15:0] px_in;
  logic [2:0]  selector;
  logic [15:0] addr;
  logic [15:0] pixel_out;
  logic        pixel_valid;
  logic [1:0]  sync_out;

  modport master (
    output px_en, frame_start, x, y, active, sync_in, px_in,
    input  selector, addr, pixel_out, pixel_valid, sync_out
  );

  modport slave (
    input  px_en, frame_start, x, y, active, sync_in, px_in,
    output selector, addr, pixel_out, pixel_valid, sync_out
  );
endinterface

// File: rtl/sprite_fetch_ctrl.sv
// Maps pixel coordinates plus frame-latched game state to a sprite-ROM select/address,
// then captures the returned pixel ROM_LATENCY cycles later with sync kept aligned.
module sprite_fetch_ctrl #(
  parameter int ROM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                power_on_i,
  input  logic [2:0]          lit_btn_i,
  input  logic [1:0]          result_i,
  sprite_fetch_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    SEL_BG     = 3'd0,
    SEL_POWER  = 3'd1,
    SEL_RED    = 3'd2,
    SEL_GREEN  = 3'd3,
    SEL_BLUE   = 3'd4,
    SEL_YELLOW = 3'd5,
    SEL_WIN    = 3'd6,
    SEL_LOSE   = 3'd7
  } sel_e;

  // Region tables indexed by the selector code of the sprite they address.
  localparam logic [9:0] RX0 [8] = '{10'd140, 10'd311, 10'd150, 10'd323,
                                     10'd150, 10'd324, 10'd204, 10'd186};
  localparam logic [9:0] RY0 [8] = '{10'd150, 10'd233, 10'd160, 10'd160,
                                     10'd240, 10'd240, 10'd195, 10'd195};
  localparam logic [9:0] RW  [8] = '{10'd360, 10'd18,  10'd167, 10'd167,
                                     10'd167, 10'd166, 10'd232, 10'd268};
  localparam logic [9:0] RH  [8] = '{10'd180, 10'd14,  10'd84,  10'd84,
                                     10'd84,  10'd84,  10'd90,  10'd90};
  localparam logic [15:0] RSIZE [8] = '{16'd64800, 16'd252,   16'd14028, 16'd14028,
                                        16'd14028, 16'd13944, 16'd20880, 16'd24120};
  localparam int RBITS [8] = '{16, 8, 14, 14, 14, 14, 15, 15};

  logic [7:0]  hit;
  logic [15:0] cnt_ext [8];

  // Every region counter runs on its own hits regardless of what is selected,
  // so a state change mid-frame never shifts any sprite's addressing.
  for (genvar g = 0; g < 8; g++) begin : g_region
    localparam int BITS = RBITS[g];
    logic [BITS-1:0] cnt_q;

    assign hit[g] = bus.active
                 && ({1'b0, bus.x} >= {1'b0, RX0[g]})
                 && ({1'b0, bus.x} <  {1'b0, RX0[g]} + {1'b0, RW[g]})
                 && ({1'b0, bus.y} >= {1'b0, RY0[g]})
                 && ({1'b0, bus.y} <  {1'b0, RY0[g]} + {1'b0, RH[g]});

    // NOTE: counters are state the address depends on, so they take the async reset
    // like any control register; a frame_start clear alone would leave X after power-up.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (bus.frame_start) begin
        cnt_q <= '0;
      end else if (bus.px_en && hit[g]) begin
        cnt_q <= (cnt_q == BITS'(RSIZE[g] - 16'd1)) ? '0 : cnt_q + 1'b1;
      end
    end

    assign cnt_ext[g] = 16'(cnt_q);
  end

  logic       pwr_sh_q;
  logic [2:0] lit_sh_q;
  logic [1:0] res_sh_q;
  logic       synced_q;

  sel_e        sel_d, sel_q;
  logic        blank_d, blank_q;
  logic [15:0] addr_d, addr_q;
  logic [1:0]  sync_q;
  logic [2:0]  lit_idx;
  logic        lit_ok;

  logic [ROM_LATENCY-1:0] vld_d, vld_q;
  logic [15:0]            pixel_out_q;
  logic                   pixel_valid_q;
  logic [1:0]             sync_out_q;

  assign lit_idx = lit_sh_q + 3'd1;
  assign lit_ok  = (lit_sh_q >= 3'd1) && (lit_sh_q <= 3'd4);

  // NOTE: every output of a combinational block gets a default first so no path
  // through the if-chain can leave it unassigned and infer a latch.
  always_comb begin
    sel_d   = SEL_BG;
    blank_d = 1'b1;
    if (hit[SEL_LOSE] && res_sh_q[1]) begin
      sel_d   = SEL_LOSE;
      blank_d = 1'b0;
    end else if (hit[SEL_WIN] && (res_sh_q == 2'd1)) begin
      sel_d   = SEL_WIN;
      blank_d = 1'b0;
    end else if (hit[SEL_POWER] && pwr_sh_q) begin
      sel_d   = SEL_POWER;
      blank_d = 1'b0;
    end else if (lit_ok && hit[lit_idx]) begin
      sel_d   = sel_e'(lit_idx);
      blank_d = 1'b0;
    end else if (hit[SEL_BG]) begin
      blank_d = 1'b0;
    end
    addr_d = blank_d ? 16'd0 : cnt_ext[sel_d];
  end

  // One-hot-per-stage tracker of the pixel in flight through the ROM.
  always_comb begin
    vld_d = (vld_q << 1) | ROM_LATENCY'(bus.px_en);
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_sh_q      <= 1'b0;
      lit_sh_q      <= 3'd0;
      res_sh_q      <= 2'd0;
      synced_q      <= 1'b0;
      sel_q         <= SEL_BG;
      addr_q        <= 16'd0;
      blank_q       <= 1'b1;
      sync_q        <= 2'b11;
      vld_q         <= '0;
      pixel_out_q   <= 16'd0;
      pixel_valid_q <= 1'b0;
      sync_out_q    <= 2'b11;
    end else begin
      if (bus.frame_start) begin
        pwr_sh_q <= power_on_i;
        lit_sh_q <= lit_btn_i;
        res_sh_q <= result_i;
        synced_q <= 1'b1;
      end
      if (bus.px_en) begin
        sel_q   <= sel_d;
        addr_q  <= addr_d;
        blank_q <= blank_d;
        sync_q  <= bus.sync_in;
      end
      vld_q         <= vld_d;
      pixel_valid_q <= vld_q[ROM_LATENCY-1];
      if (vld_q[ROM_LATENCY-1]) begin
        pixel_out_q <= (blank_q || !synced_q) ? 16'd0 : bus.px_in;
        sync_out_q  <= sync_q;
      end
    end
  end

  assign bus.selector    = sel_q;
  assign bus.addr        = addr_q;
  assign bus.pixel_out   = pixel_out_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.sync_out    = sync_out_q;

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Self-checking bench for sprite_fetch_ctrl: directed scenarios plus random pixels
// compared against a behavioural model of regions, priorities and frame shadows.
module tb_sprite_fetch_ctrl;
  localparam int L = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       power_on;
  logic [2:0] lit_btn;
  logic [1:0] result;

  sprite_fetch_ctrl_if bus ();

  sprite_fetch_ctrl #(.ROM_LATENCY(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .power_on_i (power_on),
    .lit_btn_i  (lit_btn),
    .result_i   (result),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Pixel strobes closer than L+2 cycles are illegal input.
  int  cyc     = 0;
  int  last_px = 0;
  bit  seen_px = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.px_en === 1'b1) begin
      if (seen_px) assert (cyc - last_px >= L + 2) else $error("px_en spacing violated at cycle %0d", cyc);
      last_px <= cyc;
      seen_px <= 1'b1;
    end
  end

  // Behavioural model: sprite rectangles, per-frame hit counts and latched state.
  int rx0 [8] = '{140, 311, 150, 323, 150, 324, 204, 186};
  int ry0 [8] = '{150, 233, 160, 160, 240, 240, 195, 195};
  int rw  [8] = '{360,  18, 167, 167, 167, 166, 232, 268};
  int rh  [8] = '{180,  14,  84,  84,  84,  84,  90,  90};
  int m_cnt [8];
  bit m_pwr;
  int m_lit;
  int m_res;
  bit m_synced;

  function automatic bit in_reg(int i, int x, int y);
    return (x >= rx0[i]) && (x < rx0[i] + rw[i]) && (y >= ry0[i]) && (y < ry0[i] + rh[i]);
  endfunction

  function automatic void predict(int x, int y, bit act, output int sel, output int addr,
                                  output bit blank);
    sel = 0; addr = 0; blank = 1;
    if (!act) return;
    if (m_res >= 2 && in_reg(7, x, y))                          sel = 7;
    else if (m_res == 1 && in_reg(6, x, y))                     sel = 6;
    else if (m_pwr && in_reg(1, x, y))                          sel = 1;
    else if (m_lit >= 1 && m_lit <= 4 && in_reg(m_lit + 1, x, y)) sel = m_lit + 1;
    else if (in_reg(0, x, y))                                   sel = 0;
    else return;
    blank = 0;
    addr  = m_cnt[sel];
  endfunction

  function automatic void model_frame();
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_pwr = power_on; m_lit = int'(lit_btn); m_res = int'(result); m_synced = 1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_pwr = 0; m_lit = 0; m_res = 0; m_synced = 0;
  endfunction

  task automatic frame_pulse();
    bus.frame_start = 1'b1;
    model_frame();
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
  endtask

  // Issues one pixel (optionally together with frame_start) and follows it to PIXEL_VALID.
  task automatic drive_pixel(int x, int y, bit act, bit fs, string tag);
    int es, ea; bit eb; logic [15:0] pin; logic [1:0] sy; logic [15:0] epx;
    pin = 16'($urandom);
    sy  = 2'($urandom);
    predict(x, y, act, es, ea, eb);
    bus.px_en = 1'b1; bus.frame_start = fs; bus.x = 10'(x); bus.y = 10'(y);
    bus.active = act; bus.sync_in = sy; bus.px_in = pin;
    if (fs) model_frame();
    else if (act) begin
      for (int i = 0; i < 8; i++)
        if (in_reg(i, x, y)) m_cnt[i] = (m_cnt[i] + 1) % (rw[i] * rh[i]);
    end
    epx = (eb || !m_synced) ? 16'h0000 : pin;
    @(posedge clk); #1;
    bus.px_en = 1'b0; bus.frame_start = 1'b0;
    n_total++;
    if (bus.selector !== 3'(es)) $display("FAIL %s sel (%0d,%0d): got %0d want %0d", tag, x, y, bus.selector, es);
    else n_pass++;
    n_total++;
    if (bus.addr !== 16'(ea)) $display("FAIL %s addr (%0d,%0d): got %0d want %0d", tag, x, y, bus.addr, ea);
    else n_pass++;
    for (int k = 0; k < L; k++) begin
      n_total++;
      if (bus.pixel_valid !== 1'b0) $display("FAIL %s early_valid: got %b want 0", tag, bus.pixel_valid);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_total++;
    if (bus.pixel_valid !== 1'b1) $display("FAIL %s valid: got %b want 1", tag, bus.pixel_valid);
    else n_pass++;
    n_total++;
    if (bus.pixel_out !== epx) $display("FAIL %s pixel (%0d,%0d): got %h want %h", tag, x, y, bus.pixel_out, epx);
    else n_pass++;
    n_total++;
    if (bus.sync_out !== sy) $display("FAIL %s sync: got %b want %b", tag, bus.sync_out, sy);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.pixel_valid !== 1'b0) $display("FAIL %s valid_len: got %b want 0", tag, bus.pixel_valid);
    else n_pass++;
  endtask

  task automatic check_outputs_reset(string tag);
    n_total++;
    if (bus.selector !== 3'd0 || bus.addr !== 16'd0)
      $display("FAIL %s sel/addr: got %0d/%0d want 0/0", tag, bus.selector, bus.addr);
    else n_pass++;
    n_total++;
    if (bus.pixel_out !== 16'd0 || bus.pixel_valid !== 1'b0)
      $display("FAIL %s pixel/valid: got %h/%b want 0000/0", tag, bus.pixel_out, bus.pixel_valid);
    else n_pass++;
    n_total++;
    if (bus.sync_out !== 2'b11) $display("FAIL %s sync_out: got %b want 11", tag, bus.sync_out);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.px_en = 0; bus.frame_start = 0; bus.x = 0; bus.y = 0; bus.active = 0;
    bus.sync_in = 0; bus.px_in = 0;
    power_on = 0; lit_btn = 0; result = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_first_pixel();
    power_on = 0; lit_btn = 0; result = 0;
    frame_pulse();
    drive_pixel(140, 150, 1, 0, "first");
  endtask

  task automatic test_lit_midframe();
    lit_btn = 3'd0;
    frame_pulse();
    drive_pixel(150, 240, 1, 0, "lit_old");
    lit_btn = 3'd3;
    drive_pixel(151, 240, 1, 0, "lit_hold");
    frame_pulse();
    drive_pixel(150, 240, 1, 0, "lit_new");
    n_total++;
    if (bus.selector !== 3'd4 || bus.addr !== 16'd0)
      $display("FAIL lit_blue_origin: got %0d/%0d want 4/0", bus.selector, bus.addr);
    else n_pass++;
  endtask

  // Two passes over the power icon: row-major addresses, then wrap back to 0.
  task automatic test_power_wrap();
    power_on = 1; lit_btn = 0; result = 0;
    frame_pulse();
    for (int pass = 0; pass < 2; pass++)
      for (int y = 233; y < 247; y++)
        for (int x = 311; x < 329; x++) begin
          drive_pixel(x, y, 1, 0, "power");
          n_total++;
          if (bus.addr !== 16'((y - 233) * 18 + (x - 311)))
            $display("FAIL power_rowmajor (%0d,%0d): got %0d want %0d", x, y, bus.addr, (y - 233) * 18 + (x - 311));
          else n_pass++;
        end
  endtask

  task automatic test_lose_priority();
    result = 2'd2; power_on = 1; lit_btn = 3'd1;
    frame_pulse();
    for (int y = 195; y <= 233; y++)
      for (int x = 186; x < 454; x++) begin
        if (y == 233 && x > 311) break;
        drive_pixel(x, y, 1, 0, "lose");
      end
    n_total++;
    if (bus.selector !== 3'd7 || bus.addr !== 16'd10309)
      $display("FAIL lose_over_power: got %0d/%0d want 7/10309", bus.selector, bus.addr);
    else n_pass++;
  endtask

  task automatic test_none();
    drive_pixel(10, 10, 1, 0, "outside");
    drive_pixel(300, 200, 0, 0, "inactive");
    drive_pixel(499, 329, 1, 0, "bg_corner");
    drive_pixel(500, 329, 1, 0, "bg_right");
    drive_pixel(499, 330, 1, 0, "bg_below");
  endtask

  task automatic test_fs_with_px();
    result = 0; power_on = 0; lit_btn = 3'd2;
    drive_pixel(330, 170, 1, 1, "fs_px");
    drive_pixel(323, 160, 1, 0, "fs_after");
    drive_pixel(324, 160, 1, 0, "fs_next");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) begin
        power_on = 1'($urandom); lit_btn = 3'($urandom); result = 2'($urandom);
      end
      if (n % 60 == 30) frame_pulse();
      drive_pixel(120 + $urandom_range(0, 400), 140 + $urandom_range(0, 200),
                  $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, "random");
    end
  endtask

  task automatic test_reset_midframe();
    power_on = 0; lit_btn = 0; result = 0;
    frame_pulse();
    for (int n = 0; n < 501; n++)
      drive_pixel(140 + (n % 360), 150 + n / 360, 1, 0, "pre_reset");
    n_total++;
    if (bus.addr !== 16'd500) $display("FAIL addr_500: got %0d want 500", bus.addr);
    else n_pass++;
    bus.px_en = 1'b1; bus.x = 10'd142; bus.y = 10'd151; bus.active = 1'b1;
    @(posedge clk); #1;
    bus.px_en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs_reset("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < L + 3; k++) begin
      @(posedge clk); #1;
      n_total++;
      if (bus.pixel_valid !== 1'b0) $display("FAIL dropped_pixel: got %b want 0", bus.pixel_valid);
      else n_pass++;
    end
    power_on = 1; lit_btn = 3'd1;
    drive_pixel(150, 160, 1, 0, "unsynced");
    frame_pulse();
    drive_pixel(150, 160, 1, 0, "resynced");
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_lit_midframe();
    test_power_wrap();
    test_lose_priority();
    test_none();
    test_fs_with_px();
    test_random();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
